// File: rtl/sm_input_if.sv
// Router-ejection / CPU read-port bundle for sm_input.
// master = router + CPU side, slave = the receive block.
interface sm_input_if #(
    parameter int DATA_WIDTH = 37,
    parameter int CNT_W      = 3
);
    logic [DATA_WIDTH-1:0] pkt_in;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic                  cpu_read;
    logic                  cpu_valid;
    logic [31:0]           cpu_data;
    logic                  cpu_last;
    logic [3:0]            cpu_src;
    logic [CNT_W-1:0]      fifo_count;
    logic                  rd_err;
    logic                  irq;

    modport master (
        output pkt_in, pkt_valid, cpu_read,
        input  pkt_ready, cpu_valid, cpu_data, cpu_last, cpu_src, fifo_count, rd_err, irq
    );

    modport slave (
        input  pkt_in, pkt_valid, cpu_read,
        output pkt_ready, cpu_valid, cpu_data, cpu_last, cpu_src, fifo_count, rd_err, irq
    );
endinterface

// File: rtl/sm_input.sv
// Router-to-CPU receive stage: small packet FIFO with a first-word-fall-through read port.
// Optional fill-level interrupt enabled by defining SM_INPUT_IRQ_EN.
module sm_input #(
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 3,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic       clk,
    input  logic       reset,
    sm_input_if.slave  bus
);
    localparam int PTR_W = CNT_W - 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W != $clog2(DEPTH) + 1))
        $error("sm_input: DEPTH must be a power of 2 >= 2 and CNT_W = log2(DEPTH)+1");
    if ((IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH))
        $error("sm_input: IRQ_LEVEL must lie in 1..DEPTH");

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      nextCount;
    logic                  rdErr;
    logic                  pktReady;
    logic                  cpuValid;
    logic                  doWrite;
    logic                  doRead;
    logic [DATA_WIDTH-1:0] head;

    // Flow control comes only from the registered count, never from cpu_read.
    assign pktReady = (count != CNT_W'(DEPTH));
    assign cpuValid = (count != '0);
    assign doWrite  = bus.pkt_valid & pktReady;
    assign doRead   = bus.cpu_read & cpuValid;

    always_comb begin
        nextCount = count;
        if (doWrite && !doRead)
            nextCount = count + 1'b1;
        else if (doRead && !doWrite)
            nextCount = count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            rdErr <= 1'b0;
        end else begin
            if (doWrite)
                wrPtr <= wrPtr + 1'b1;
            if (doRead)
                rdPtr <= rdPtr + 1'b1;
            count <= nextCount;
            if (bus.cpu_read && !cpuValid)
                rdErr <= 1'b1;
        end
    end

    // Packet storage carries no reset; contents are only observed while cpu_valid is high.
    always_ff @(posedge clk) begin
        if (doWrite)
            mem[wrPtr] <= bus.pkt_in;
    end

    assign head           = mem[rdPtr];
    assign bus.pkt_ready  = pktReady;
    assign bus.cpu_valid  = cpuValid;
    assign bus.cpu_data   = head[DATA_WIDTH-1:5];
    assign bus.cpu_last   = head[4];
    assign bus.cpu_src    = head[3:0];
    assign bus.fifo_count = count;
    assign bus.rd_err     = rdErr;

`ifdef SM_INPUT_IRQ_EN
    logic irqReg;

    // Tracks the post-edge fill level, so irq moves on the same edge as fifo_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irqReg <= 1'b0;
        else
            irqReg <= (nextCount >= CNT_W'(IRQ_LEVEL));
    end

    assign bus.irq = irqReg;
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_sm_input.sv
// Scoreboard bench for sm_input: driver pushes accepted packets, monitor pops on every CPU read.
module tb_sm_input;
    localparam int DW        = 37;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 3;
    localparam int IRQ_LEVEL = 2;

`ifdef SM_INPUT_IRQ_EN
    localparam logic IRQ_AT_LEVEL = 1'b1;
`else
    localparam logic IRQ_AT_LEVEL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sm_input_if #(.DATA_WIDTH(DW), .CNT_W(CNT_W)) bus ();

    sm_input #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .IRQ_LEVEL (IRQ_LEVEL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [DW-1:0] expQ[$];
    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp)
            passCnt++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] mkPkt(input logic [31:0] d, input logic l, input logic [3:0] s);
        return {d, l, s};
    endfunction

    // Monitor: every read that the DUT will honour on the next edge must match the queue head.
    always @(negedge clk) begin
        logic [DW-1:0] exp;
        if (!reset && bus.cpu_read && bus.cpu_valid) begin
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL pop_unexpected: got packet %h, expected none", {bus.cpu_data, bus.cpu_last, bus.cpu_src});
            end else begin
                exp = expQ.pop_front();
                check("pop_data", 64'(bus.cpu_data), 64'(exp[36:5]));
                check("pop_last", 64'(bus.cpu_last), 64'(exp[4]));
                check("pop_src",  64'(bus.cpu_src),  64'(exp[3:0]));
            end
        end
    end

    task automatic pushWrite(input logic [DW-1:0] p);
        bus.pkt_in    = p;
        bus.pkt_valid = 1'b1;
        @(posedge clk);
        expQ.push_back(p);
        #1;
        bus.pkt_valid = 1'b0;
    endtask

    task automatic readOne;
        bus.cpu_read = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] p5 [1:5];

        reset         = 1'b1;
        bus.pkt_in    = '0;
        bus.pkt_valid = 1'b0;
        bus.cpu_read  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready",  64'(bus.pkt_ready),  64'd1);
        check("rst_valid",  64'(bus.cpu_valid),  64'd0);
        check("rst_count",  64'(bus.fifo_count), 64'd0);
        check("rst_rderr",  64'(bus.rd_err),     64'd0);
        check("rst_irq",    64'(bus.irq),        64'd0);

        // Fill to 3 then reset asynchronously mid-run
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) pushWrite(mkPkt(32'h1000 + 32'(i), 1'b0, 4'(i)));
        @(negedge clk);
        check("mid_count3", 64'(bus.fifo_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.pkt_ready),  64'd1);
        check("mid_rst_valid", 64'(bus.cpu_valid),  64'd0);
        check("mid_rst_count", 64'(bus.fifo_count), 64'd0);
        check("mid_rst_rderr", 64'(bus.rd_err),     64'd0);
        check("mid_rst_irq",   64'(bus.irq),        64'd0);
        expQ.delete();
        @(posedge clk); #1 reset = 1'b0;

        // Single packet fall-through
        pushWrite(mkPkt(32'hDEADBEEF, 1'b1, 4'h5));
        @(negedge clk);
        check("one_valid", 64'(bus.cpu_valid),  64'd1);
        check("one_data",  64'(bus.cpu_data),   64'hDEADBEEF);
        check("one_last",  64'(bus.cpu_last),   64'd1);
        check("one_src",   64'(bus.cpu_src),    64'd5);
        check("one_count", 64'(bus.fifo_count), 64'd1);
        readOne();
        @(negedge clk);
        check("one_empty", 64'(bus.fifo_count), 64'd0);

        // Five back-to-back writes into a depth-4 FIFO
        for (int k = 1; k <= 5; k++) p5[k] = mkPkt(32'hA0000000 + 32'(k), (k == 5), 4'(k));
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            bus.pkt_in    = p5[k];
            bus.pkt_valid = 1'b1;
            @(negedge clk);
            check("full_ready_pre", 64'(bus.pkt_ready), 64'd1);
            @(posedge clk);
            expQ.push_back(p5[k]);
            #1;
        end
        bus.pkt_in = p5[5];
        @(negedge clk);
        check("full_ready", 64'(bus.pkt_ready),  64'd0);
        check("full_count", 64'(bus.fifo_count), 64'd4);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_hold", 64'(bus.pkt_ready), 64'd0);
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        @(negedge clk);
        check("full_ready_rd", 64'(bus.pkt_ready), 64'd0);
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        check("freed_ready", 64'(bus.pkt_ready),  64'd1);
        check("freed_count", 64'(bus.fifo_count), 64'd3);
        @(posedge clk);
        expQ.push_back(p5[5]);
        #1 bus.pkt_valid = 1'b0;
        @(negedge clk);
        check("refull_count", 64'(bus.fifo_count), 64'd4);
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.cpu_read = 1'b0;
        @(negedge clk);
        check("drain_count", 64'(bus.fifo_count), 64'd0);
        check("drain_valid", 64'(bus.cpu_valid),  64'd0);

        // Streaming at count=1 with simultaneous write and read
        @(posedge clk); #1;
        pushWrite(mkPkt(32'hC0DE0000, 1'b0, 4'h0));
        for (int i = 1; i <= 20; i++) begin
            bus.pkt_in    = mkPkt(32'hC0DE0000 + 32'(i), i[0], i[3:0]);
            bus.pkt_valid = 1'b1;
            bus.cpu_read  = 1'b1;
            @(negedge clk);
            check("stream_count", 64'(bus.fifo_count), 64'd1);
            check("stream_valid", 64'(bus.cpu_valid),  64'd1);
            @(posedge clk);
            expQ.push_back(bus.pkt_in);
            #1;
        end
        bus.pkt_valid = 1'b0;
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        check("stream_end_count", 64'(bus.fifo_count), 64'd0);

        // Read while empty
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        @(negedge clk);
        check("err_pre_valid", 64'(bus.cpu_valid), 64'd0);
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        check("err_set",   64'(bus.rd_err),     64'd1);
        check("err_count", 64'(bus.fifo_count), 64'd0);
        check("err_valid", 64'(bus.cpu_valid),  64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", 64'(bus.rd_err), 64'd1);
        pushWrite(mkPkt(32'h12345678, 1'b1, 4'hA));
        @(negedge clk);
        check("err_wr_count", 64'(bus.fifo_count), 64'd1);
        check("err_wr_data",  64'(bus.cpu_data),   64'h12345678);
        check("err_wr_src",   64'(bus.cpu_src),    64'hA);
        readOne();
        @(negedge clk);
        check("err_rd_count", 64'(bus.fifo_count), 64'd0);
        check("err_still",    64'(bus.rd_err),     64'd1);

        // Fill-level interrupt at IRQ_LEVEL=2
        pushWrite(mkPkt(32'h0000AAAA, 1'b0, 4'h1));
        @(negedge clk);
        check("irq_lvl1", 64'(bus.irq), 64'd0);
        pushWrite(mkPkt(32'h0000BBBB, 1'b1, 4'h2));
        @(negedge clk);
        check("irq_lvl2", 64'(bus.irq), 64'(IRQ_AT_LEVEL));
        readOne();
        @(negedge clk);
        check("irq_drop",       64'(bus.irq),        64'd0);
        check("irq_drop_count", 64'(bus.fifo_count), 64'd1);
        readOne();
        @(negedge clk);
        check("irq_empty", 64'(bus.irq), 64'd0);

        @(negedge clk);
        check("queue_empty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
